// File: rtl/req_issue.sv
// Credit-gated request issuer: pops a show-ahead FIFO into a single-entry
// downstream request register, tracking credits, accepted count and flush.
module req_issue #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CREDIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_read_en_o,
    input  logic                  flush_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [DATA_WIDTH-1:0] req_data_o,
    input  logic                  resp_done_i,
    output logic [2:0]            credit_o,
    output logic [15:0]           issued_cnt_o,
    output logic [1:0]            state_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_CRED_WAIT = 2'd2,
        S_FLUSH     = 2'd3
    } state_t;

    localparam logic [2:0] MAX_C = 3'(MAX_CREDIT);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [2:0]              r_credit;
    logic [2:0]              w_credit_next;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [15:0]             r_cnt;
    logic                    r_err;

    logic w_pop;
    logic w_discard;
    logic w_hs;
    logic w_overflow;

    // A pop may only refill the request slot if it is empty or being accepted now.
    assign w_pop = !fifo_empty_i && (r_credit != 3'd0) && !flush_i &&
                   (!r_valid || req_ready_i) &&
                   ((r_state == S_IDLE) || (r_state == S_ISSUE));
    assign w_discard  = (r_state == S_FLUSH) && !fifo_empty_i;
    assign w_hs       = r_valid && req_ready_i;
    assign w_overflow = resp_done_i && !w_pop && (r_credit == MAX_C);

    assign fifo_read_en_o = rst_n && (w_pop || w_discard);
    assign req_valid_o    = r_valid;
    assign req_data_o     = r_data;
    assign credit_o       = r_credit;
    assign issued_cnt_o   = r_cnt;
    assign state_o        = r_state;
    assign err_o          = r_err;

    always_comb begin
        w_credit_next = r_credit;
        if (w_pop && !resp_done_i) begin
            w_credit_next = r_credit - 3'd1;
        end else if (resp_done_i && !w_pop && !w_overflow) begin
            w_credit_next = r_credit + 3'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty_i) w_state_next = S_ISSUE;
                end
                S_ISSUE: begin
                    if (!fifo_empty_i && (r_credit == 3'd0)) w_state_next = S_CRED_WAIT;
                    else if (fifo_empty_i && !r_valid)      w_state_next = S_IDLE;
                end
                // Leave as soon as a credit is coming back so the next pop is not delayed.
                S_CRED_WAIT: begin
                    if (w_credit_next != 3'd0) w_state_next = S_ISSUE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_credit <= MAX_C;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_cnt    <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_credit <= w_credit_next;
            if (w_pop) begin
                r_valid <= 1'b1;
                r_data  <= fifo_rdata_i;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_hs)       r_cnt <= r_cnt + 16'd1;
            if (w_overflow) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_req_issue.sv
// Bench for req_issue: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of the issue/credit/flush rules.
module tb_req_issue;

    localparam int DW   = 8;
    localparam int MAXC = 4;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_rdata_i;
    logic          fifo_read_en_o;
    logic          flush_i;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [DW-1:0] req_data_o;
    logic          resp_done_i;
    logic [2:0]    credit_o;
    logic [15:0]   issued_cnt_o;
    logic [1:0]    state_o;
    logic          err_o;

    req_issue #(.DATA_WIDTH(DW), .MAX_CREDIT(MAXC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_read_en_o(fifo_read_en_o),
        .flush_i       (flush_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_data_o    (req_data_o),
        .resp_done_i   (resp_done_i),
        .credit_o      (credit_o),
        .issued_cnt_o  (issued_cnt_o),
        .state_o       (state_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Upstream FIFO contents and the reference view of the block.
    logic [DW-1:0] fifo_q[$];
    int            m_state;   // 0 idle, 1 issue, 2 credit wait, 3 flush
    int            m_credit;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_cnt;
    bit            m_err;
    int            pops_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_credit = MAXC;
        m_valid  = 0;
        m_data   = '0;
        m_cnt    = 0;
        m_err    = 0;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    task automatic check_reset_values();
        check("rst_valid",  32'(req_valid_o),  32'd0);
        check("rst_data",   32'(req_data_o),   32'd0);
        check("rst_credit", 32'(credit_o),     32'(MAXC));
        check("rst_cnt",    32'(issued_cnt_o), 32'd0);
        check("rst_state",  32'(state_o),      32'd0);
        check("rst_err",    32'(err_o),        32'd0);
        check("rst_rden",   32'(fifo_read_en_o), 32'd0);
    endtask

    // Asserts reset asynchronously (no clock edge before the checks).
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        fifo_q.delete();
        fifo_empty_i = 1'b1;
        flush_i = 1'b0;
        req_ready_i = 1'b0;
        resp_done_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive, compare with the model, then advance the model.
    task automatic step(input bit rdy, input bit resp, input bit fl);
        bit empty, pop, disc, hs, new_cred_nz;
        req_ready_i = rdy;
        resp_done_i = resp;
        flush_i     = fl;
        empty = (fifo_q.size() == 0);
        fifo_empty_i = empty;
        fifo_rdata_i = empty ? DW'($urandom) : fifo_q[0];
        #2;
        pop  = !empty && m_credit != 0 && !fl && (!m_valid || rdy) && (m_state == 0 || m_state == 1);
        disc = (m_state == 3) && !empty;
        hs   = m_valid && rdy;
        check("rd_en",  32'(fifo_read_en_o), 32'(pop || disc));
        check("valid",  32'(req_valid_o),    32'(m_valid));
        if (m_valid) check("data", 32'(req_data_o), 32'(m_data));
        check("credit", 32'(credit_o),       32'(m_credit));
        check("cnt",    32'(issued_cnt_o),   32'(m_cnt));
        check("state",  32'(state_o),        32'(m_state));
        check("err",    32'(err_o),          32'(m_err));

        if (pop && !resp) m_credit--;
        else if (resp && !pop) begin
            if (m_credit == MAXC) m_err = 1;
            else m_credit++;
        end
        new_cred_nz = (m_credit != 0);
        if (fl) m_state = 3;
        else begin
            case (m_state)
                0: if (!empty) m_state = 1;
                1: begin
                    if (!empty && m_credit_prev_zero(pop, resp)) m_state = 2;
                    else if (empty && !m_valid) m_state = 0;
                end
                2: if (new_cred_nz) m_state = 1;
                default: m_state = 0;
            endcase
        end
        if (pop) begin
            m_valid = 1;
            m_data  = fifo_q[0];
        end else if (hs) m_valid = 0;
        if (hs) m_cnt = (m_cnt + 1) % 65536;
        if (pop || disc) begin
            void'(fifo_q.pop_front());
            pops_seen++;
        end
        @(posedge clk);
        #1;
    endtask

    // Credit as it stood at the start of the cycle is zero (undo this cycle's update).
    function automatic bit m_credit_prev_zero(input bit pop, input bit resp);
        int c;
        c = m_credit;
        if (pop && !resp) c++;
        else if (resp && !pop && !(m_err && c == MAXC)) c--;
        return (c == 0);
    endfunction

    int flush_left;

    initial begin
        rst_n = 1'b1;
        fifo_empty_i = 1'b1;
        fifo_rdata_i = '0;
        flush_i = 1'b0;
        req_ready_i = 1'b0;
        resp_done_i = 1'b0;
        pops_seen = 0;
        #2;
        do_reset();

        // Three words, ready high, no responses.
        push(3);
        pops_seen = 0;
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("burst3_pops",   32'(pops_seen),    32'd3);
        check("burst3_credit", 32'(credit_o),     32'd1);
        check("burst3_cnt",    32'(issued_cnt_o), 32'd3);

        // Six words against four credits, then a single credit return.
        do_reset();
        push(6);
        pops_seen = 0;
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        check("cred_pops",  32'(pops_seen), 32'd4);
        check("cred_state", 32'(state_o),   32'd2);
        check("cred_rden",  32'(fifo_read_en_o), 32'd0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("cred_one_more", 32'(pops_seen), 32'd5);

        // Backpressure: request held, no pop while not ready.
        do_reset();
        push(2);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check("bp_held_fifo", 32'(fifo_q.size()), 32'd1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);

        // Flush with a held request and three words behind it.
        do_reset();
        push(1);
        step(0, 0, 0);
        push(3);
        pops_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check("flush_pops",   32'(pops_seen),   32'd3);
        check("flush_valid",  32'(req_valid_o), 32'd1);
        check("flush_credit", 32'(credit_o),    32'(MAXC - 1));
        step(0, 0, 0);
        check("flush_idle",   32'(state_o),     32'd0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Credit return at full credit sets the sticky error.
        do_reset();
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("ovf_err",    32'(err_o),    32'd1);
        check("ovf_credit", 32'(credit_o), 32'(MAXC));
        do_reset();

        // Random traffic.
        flush_left = 0;
        for (int i = 0; i < 600; i++) begin
            bit rdy, resp, fl;
            if (fifo_q.size() < 6 && ($urandom % 2) == 1) push(int'($urandom % 3));
            rdy  = ($urandom % 4) != 0;
            resp = (m_credit < MAXC && ($urandom % 2) == 1) || ($urandom % 80) == 0;
            if (flush_left == 0 && ($urandom % 40) == 0) flush_left = int'($urandom_range(1, 4));
            fl = (flush_left != 0);
            if (flush_left != 0) flush_left--;
            step(rdy, resp, fl);
        end

        // Asynchronous reset in the middle of a burst.
        push(4);
        step(1, 0, 0);
        step(1, 0, 0);
        do_reset();
        push(2);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/req_issue.md
REQ_ISSUE -- requirements
Module: req_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of request word popped from the upstream FIFO.
REQ-002 Parameter MAX_CREDIT, default 4, maximum outstanding requests downstream (range 1..7).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-006 Port fifo_rdata_i  input  DATA_WIDTH  upstream FIFO head word (show-ahead, valid while !fifo_empty_i).
REQ-007 Port fifo_read_en_o  output  1  pop strobe to upstream FIFO.
REQ-008 Port flush_i  input  1  level; discard FIFO contents while high.
REQ-009 Port req_valid_o  output  1  downstream request valid.
REQ-010 Port req_ready_i  input  1  downstream accept.
REQ-011 Port req_data_o  output  DATA_WIDTH  downstream request word.
REQ-012 Port resp_done_i  input  1  one credit returned per cycle high.
REQ-013 Port credit_o  output  3  credits currently available.
REQ-014 Port issued_cnt_o  output  16  requests accepted downstream since reset.
REQ-015 Port state_o  output  2  FSM state encoding.
REQ-016 Port err_o  output  1  sticky credit-overflow error.

Function
REQ-017 pop = !fifo_empty_i & credit_o!=0 & !flush_i & (!req_valid_o | req_ready_i), in FSM ISSUE or IDLE; fifo_read_en_o = pop | flush-discard, combinational.
REQ-018 On pop, fifo_rdata_i registered into req_data_o; req_valid_o high next cycle (latency 1 from pop).
REQ-019 Throughput one request per cycle while req_ready_i high and credit available.
REQ-020 Once high, req_valid_o and req_data_o held stable until req_ready_i sampled high; flush_i never drops an already-valid request.
REQ-021 Handshake complete when req_valid_o & req_ready_i; req_valid_o clears next cycle unless a pop occurs the same cycle.
REQ-022 Credit decremented on pop, incremented on resp_done_i; both in one cycle leave credit unchanged.
REQ-023 resp_done_i with credit_o==MAX_CREDIT and no pop: credit saturates, err_o set and held until reset.
REQ-024 issued_cnt_o increments on each completed handshake; wraps 0xFFFF->0x0000.
REQ-025 FSM: IDLE=0, ISSUE=1, CRED_WAIT=2, FLUSH=3.
REQ-026 IDLE->FLUSH if flush_i; else IDLE->ISSUE if !fifo_empty_i.
REQ-027 ISSUE->FLUSH if flush_i; ISSUE->CRED_WAIT if !fifo_empty_i & credit_o==0; ISSUE->IDLE if fifo_empty_i & !req_valid_o.
REQ-028 CRED_WAIT->FLUSH if flush_i; CRED_WAIT->ISSUE when credit_o becomes nonzero; no pops in CRED_WAIT.
REQ-029 FLUSH: fifo_read_en_o = !fifo_empty_i each cycle, popped words discarded, credit unchanged; FLUSH->IDLE when flush_i low.
REQ-030 flush_i takes priority over all other transitions.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, req_valid_o 0, req_data_o 0, credit_o MAX_CREDIT, issued_cnt_o 0, err_o 0.
REQ-032 fifo_read_en_o is 0 while rst_n low, independent of inputs.
REQ-033 Reset mid-transfer drops any held request; no credit state retained.

Verification
REQ-034 Reset, FIFO holds 3 words, req_ready_i=1, no resp -> pops cycles 0..2, req_valid_o cycles 1..3, credit_o 4->1, issued_cnt_o=3.
REQ-035 FIFO holds 6 words, MAX_CREDIT=4, no resp -> 4 issued, state_o=2, fifo_read_en_o low; one resp_done_i -> exactly one further pop next cycle.
REQ-036 req_ready_i low 5 cycles with req_valid_o high -> req_data_o stable, no pop; ready high -> handshake, pop same cycle.
REQ-037 flush_i high 4 cycles with 3 FIFO words and held valid request -> 3 discard pops, request still held until accepted, credit_o unchanged, state_o 3->0.
REQ-038 resp_done_i at credit_o=4 -> credit_o stays 4, err_o=1 until rst_n low.
REQ-039 rst_n low asynchronously mid-burst -> outputs at reset values without a clock edge.
